ps2_key_decoder: RTL and testbench

Receive-only PS/2 keyboard front end that turns the KEY_CLK/KEY_DATA pins into held-key control levels for the Tetris core. Outputs are active-low and button-shaped, so the top level can AND them with the push-buttons before the existing debouncers on right/left/rotateR/verticalspeed. The block runs in the VGA pixel clock domain produced by div_clk.

---
 rtl/ps2_key_decoder.sv | 216 +++++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver turning scan codes into active-low held-key levels.
// Optional: define PS2_GLITCH_FILTER_EN to debounce key_clk over FILTER_LEN cycles.
// Ports: clk, rst_n (async, active low); key_clk/key_data (PS/2 pins, async)
//   right_n/left_n/rotate_n/speed_n : low while the mapped key is held
//   scan_code/scan_ext/scan_brk     : last non-prefix byte and its prefixes
//   scan_valid                      : one-cycle pulse on scan_* update
//   frame_err                       : one-cycle pulse on parity/stop/timeout error
module ps2_key_decoder #(
  parameter int TIMEOUT_CYCLES = 25000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_clk,
  input  logic       key_data,
  output logic       right_n,
  output logic       left_n,
  output logic       rotate_n,
  output logic       speed_n,
  output logic [7:0] scan_code,
  output logic       scan_ext,
  output logic       scan_brk,
  output logic       scan_valid,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  if (FILTER_LEN < 2) begin : g_chk_filter
    $error("FILTER_LEN must be at least 2");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_chk_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic          r_kclk_s1, r_kclk_s2;
  logic          r_kdat_s1, r_kdat_s2;
  logic          r_kclk_prev;
  logic          w_kclk_lvl;
  logic          w_fall;

  state_t        r_state, w_state_nx;
  logic [7:0]    r_shift;
  logic [2:0]    r_bitcnt;
  logic          r_par;
  logic [TW-1:0] r_to_cnt;
  logic          w_byte_ok, w_byte_bad, w_timeout;
  logic          r_byte_vld;
  logic          r_frame_err;

  logic          r_ext, r_brk;
  logic [7:0]    r_scan_code;
  logic          r_scan_ext, r_scan_brk, r_scan_valid;
  logic          r_right_n, r_left_n, r_rotate_n, r_speed_n;
  logic          w_is_e0, w_is_f0;
  logic          w_hit_right, w_hit_left, w_hit_rot, w_hit_spd;

  // Idle bus is high, so sync flops reset high to avoid a fake edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kclk_s1 <= 1'b1;
      r_kclk_s2 <= 1'b1;
      r_kdat_s1 <= 1'b1;
      r_kdat_s2 <= 1'b1;
    end else begin
      r_kclk_s1 <= key_clk;
      r_kclk_s2 <= r_kclk_s1;
      r_kdat_s1 <= key_data;
      r_kdat_s2 <= r_kdat_s1;
    end
  end

`ifdef PS2_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);
  logic [FW-1:0] r_flt_cnt;
  logic          r_flt_lvl;

  // Level flips only after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flt_cnt <= '0;
      r_flt_lvl <= 1'b1;
    end else if (r_kclk_s2 == r_flt_lvl) begin
      r_flt_cnt <= '0;
    end else if (r_flt_cnt == FW'(FILTER_LEN - 1)) begin
      r_flt_cnt <= '0;
      r_flt_lvl <= r_kclk_s2;
    end else begin
      r_flt_cnt <= r_flt_cnt + 1'b1;
    end
  end

  assign w_kclk_lvl = r_flt_lvl;
`else
  assign w_kclk_lvl = r_kclk_s2;
`endif

  assign w_fall = r_kclk_prev & ~w_kclk_lvl;

  always_comb begin
    w_state_nx = r_state;
    w_byte_ok  = 1'b0;
    w_byte_bad = 1'b0;
    w_timeout  = 1'b0;
    if (r_state != S_IDLE && !w_fall &&
        r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
      w_timeout  = 1'b1;
      w_state_nx = S_IDLE;
    end else if (w_fall) begin
      unique case (r_state)
        S_IDLE:   if (!r_kdat_s2) w_state_nx = S_DATA;
        S_DATA:   if (r_bitcnt == 3'd7) w_state_nx = S_PARITY;
        S_PARITY: w_state_nx = S_STOP;
        S_STOP: begin
          w_state_nx = S_IDLE;
          if (r_kdat_s2 && (^{r_shift, r_par})) w_byte_ok = 1'b1;
          else w_byte_bad = 1'b1;
        end
        default:  w_state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_kclk_prev <= 1'b1;
      r_shift     <= '0;
      r_bitcnt    <= '0;
      r_par       <= 1'b0;
      r_to_cnt    <= '0;
      r_byte_vld  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_kclk_prev <= w_kclk_lvl;
      r_byte_vld  <= w_byte_ok;
      r_frame_err <= w_byte_bad | w_timeout;
      if (w_fall || w_timeout || r_state == S_IDLE) r_to_cnt <= '0;
      else r_to_cnt <= r_to_cnt + 1'b1;
      if (w_fall) begin
        if (r_state == S_IDLE) r_bitcnt <= '0;
        if (r_state == S_DATA) begin
          r_shift  <= {r_kdat_s2, r_shift[7:1]};
          r_bitcnt <= r_bitcnt + 3'd1;
        end
        if (r_state == S_PARITY) r_par <= r_kdat_s2;
      end
    end
  end

  // r_shift holds the finished byte until the next frame starts shifting.
  assign w_is_e0     = (r_shift == 8'hE0);
  assign w_is_f0     = (r_shift == 8'hF0);
  assign w_hit_right = r_ext ? (r_shift == 8'h74) : (r_shift == 8'h23);
  assign w_hit_left  = r_ext ? (r_shift == 8'h6B) : (r_shift == 8'h1C);
  assign w_hit_rot   = r_ext ? (r_shift == 8'h75) : (r_shift == 8'h1D);
  assign w_hit_spd   = r_ext ? (r_shift == 8'h72) : (r_shift == 8'h1B);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ext        <= 1'b0;
      r_brk        <= 1'b0;
      r_scan_code  <= 8'h00;
      r_scan_ext   <= 1'b0;
      r_scan_brk   <= 1'b0;
      r_scan_valid <= 1'b0;
      r_right_n    <= 1'b1;
      r_left_n     <= 1'b1;
      r_rotate_n   <= 1'b1;
      r_speed_n    <= 1'b1;
    end else begin
      r_scan_valid <= 1'b0;
      if (w_byte_bad || w_timeout) begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end else if (r_byte_vld) begin
        unique case (1'b1)
          w_is_e0: r_ext <= 1'b1;
          w_is_f0: r_brk <= 1'b1;
          default: begin
            r_scan_code  <= r_shift;
            r_scan_ext   <= r_ext;
            r_scan_brk   <= r_brk;
            r_scan_valid <= 1'b1;
            r_ext        <= 1'b0;
            r_brk        <= 1'b0;
            // Make drives low, break releases.
            if (w_hit_right) r_right_n  <= r_brk;
            if (w_hit_left)  r_left_n   <= r_brk;
            if (w_hit_rot)   r_rotate_n <= r_brk;
            if (w_hit_spd)   r_speed_n  <= r_brk;
          end
        endcase
      end
    end
  end

  assign right_n    = r_right_n;
  assign left_n     = r_left_n;
  assign rotate_n   = r_rotate_n;
  assign speed_n    = r_speed_n;
  assign scan_code  = r_scan_code;
  assign scan_ext   = r_scan_ext;
  assign scan_brk   = r_scan_brk;
  assign scan_valid = r_scan_valid;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: PS/2 frames driven on the pins,
// held-key levels, scan outputs and error pulses checked per scenario.
module tb_ps2_key_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_clk = 1'b1;
  logic       key_data = 1'b1;
  logic       right_n, left_n, rotate_n, speed_n;
  logic [7:0] scan_code;
  logic       scan_ext, scan_brk, scan_valid, frame_err;

  int n_chk = 0;
  int n_err = 0;
  int n_valid = 0;
  int n_ferr = 0;

  localparam int FAST = 20;
  localparam int SLOW = 750;

  ps2_key_decoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_clk    (key_clk),
    .key_data   (key_data),
    .right_n    (right_n),
    .left_n     (left_n),
    .rotate_n   (rotate_n),
    .speed_n    (speed_n),
    .scan_code  (scan_code),
    .scan_ext   (scan_ext),
    .scan_brk   (scan_brk),
    .scan_valid (scan_valid),
    .frame_err  (frame_err)
  );

  always #20 clk = ~clk;

  always @(negedge clk) begin
    if (scan_valid) n_valid++;
    if (frame_err) n_ferr++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic ps2_bit(input logic b, input int half);
    key_data = b;
    wait_cyc(half);
    key_clk = 1'b0;
    wait_cyc(half);
    key_clk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par,
                           input int half);
    logic p;
    p = ~(^b) ^ bad_par;
    ps2_bit(1'b0, half);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], half);
    ps2_bit(p, half);
    ps2_bit(1'b1, half);
    key_data = 1'b1;
    wait_cyc(half);
  endtask

  task automatic test_reset();
    wait_cyc(5);
    n_chk++;
    if ({right_n, left_n, rotate_n, speed_n} !== 4'b1111) begin
      n_err++;
      $display("FAIL reset_held: got %b want 1111",
               {right_n, left_n, rotate_n, speed_n});
    end
    n_chk++;
    if (scan_code !== 8'h00) begin
      n_err++;
      $display("FAIL reset_code: got %h want 00", scan_code);
    end
    n_chk++;
    if ({scan_ext, scan_brk, scan_valid, frame_err} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 0000",
               {scan_ext, scan_brk, scan_valid, frame_err});
    end
    rst_n = 1'b1;
    wait_cyc(5);
  endtask

  task automatic test_left();
    int v0, e0;
    v0 = n_valid;
    e0 = n_ferr;
    send_byte(8'h1C, 1'b0, SLOW);
    n_chk++;
    if (n_valid - v0 !== 1) begin
      n_err++;
      $display("FAIL left_make_valid: got %0d pulses want 1", n_valid - v0);
    end
    n_chk++;
    if ({scan_code, scan_ext, scan_brk} !== {8'h1C, 2'b00}) begin
      n_err++;
      $display("FAIL left_make_code: got %h e%b b%b want 1C e0 b0",
               scan_code, scan_ext, scan_brk);
    end
    n_chk++;
    if ({right_n, left_n, rotate_n, speed_n} !== 4'b1011) begin
      n_err++;
      $display("FAIL left_make_held: got %b want 1011",
               {right_n, left_n, rotate_n, speed_n});
    end
    send_byte(8'hF0, 1'b0, FAST);
    send_byte(8'h1C, 1'b0, FAST);
    n_chk++;
    if ({left_n, scan_brk, scan_ext} !== 3'b110) begin
      n_err++;
      $display("FAIL left_break: got left_n%b brk%b ext%b want 1 1 0",
               left_n, scan_brk, scan_ext);
    end
    n_chk++;
    if (n_valid - v0 !== 2 || n_ferr !== e0) begin
      n_err++;
      $display("FAIL left_counts: got valid %0d err %0d want 2 0",
               n_valid - v0, n_ferr - e0);
    end
  endtask

  task automatic test_arrow_right();
    int v0;
    v0 = n_valid;
    send_byte(8'hE0, 1'b0, FAST);
    n_chk++;
    if (n_valid !== v0) begin
      n_err++;
      $display("FAIL e0_no_valid: got %0d pulses want 0", n_valid - v0);
    end
    send_byte(8'h74, 1'b0, FAST);
    n_chk++;
    if ({right_n, scan_ext, scan_brk, scan_code} !== {3'b010, 8'h74}) begin
      n_err++;
      $display("FAIL right_make: got r%b e%b b%b %h want 0 1 0 74",
               right_n, scan_ext, scan_brk, scan_code);
    end
    send_byte(8'hE0, 1'b0, FAST);
    send_byte(8'hF0, 1'b0, FAST);
    send_byte(8'h74, 1'b0, FAST);
    n_chk++;
    if ({right_n, scan_ext, scan_brk} !== 3'b111) begin
      n_err++;
      $display("FAIL right_break: got r%b e%b b%b want 1 1 1",
               right_n, scan_ext, scan_brk);
    end
    n_chk++;
    if (n_valid - v0 !== 2) begin
      n_err++;
      $display("FAIL right_valid_count: got %0d want 2", n_valid - v0);
    end
  endtask

  task automatic test_parity_err();
    int v0, e0;
    v0 = n_valid;
    e0 = n_ferr;
    send_byte(8'h1D, 1'b1, FAST);
    n_chk++;
    if (n_ferr - e0 !== 1 || n_valid !== v0) begin
      n_err++;
      $display("FAIL parity_err: got err %0d valid %0d want 1 0",
               n_ferr - e0, n_valid - v0);
    end
    n_chk++;
    if (rotate_n !== 1'b1) begin
      n_err++;
      $display("FAIL parity_rot_hold: got %b want 1", rotate_n);
    end
    send_byte(8'h1D, 1'b0, FAST);
    n_chk++;
    if ({right_n, left_n, rotate_n, speed_n} !== 4'b1101) begin
      n_err++;
      $display("FAIL parity_recover: got %b want 1101",
               {right_n, left_n, rotate_n, speed_n});
    end
    n_chk++;
    if (n_ferr - e0 !== 1 || n_valid - v0 !== 1) begin
      n_err++;
      $display("FAIL parity_counts: got err %0d valid %0d want 1 1",
               n_ferr - e0, n_valid - v0);
    end
  endtask

  task automatic test_timeout();
    int e0;
    e0 = n_ferr;
    ps2_bit(1'b0, FAST);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1, FAST);
    // FAST cycles have elapsed since the last falling edge.
    wait_cyc(24950 - FAST);
    n_chk++;
    if (n_ferr !== e0) begin
      n_err++;
      $display("FAIL timeout_early: got %0d errors want 0", n_ferr - e0);
    end
    wait_cyc(150);
    n_chk++;
    if (n_ferr - e0 !== 1) begin
      n_err++;
      $display("FAIL timeout_fire: got %0d errors want 1", n_ferr - e0);
    end
    wait_cyc(30000 - 25100);
    send_byte(8'h1B, 1'b0, FAST);
    n_chk++;
    if ({right_n, left_n, rotate_n, speed_n, scan_code} !==
        {4'b1100, 8'h1B}) begin
      n_err++;
      $display("FAIL timeout_recover: got %b %h want 1100 1B",
               {right_n, left_n, rotate_n, speed_n}, scan_code);
    end
  endtask

  task automatic test_shared();
    int v0;
    send_byte(8'h23, 1'b0, FAST);
    send_byte(8'hE0, 1'b0, FAST);
    send_byte(8'h74, 1'b0, FAST);
    n_chk++;
    if (right_n !== 1'b0) begin
      n_err++;
      $display("FAIL shared_hold: got %b want 0", right_n);
    end
    send_byte(8'h23, 1'b0, FAST);
    n_chk++;
    if (right_n !== 1'b0) begin
      n_err++;
      $display("FAIL shared_repeat: got %b want 0", right_n);
    end
    send_byte(8'hE0, 1'b0, FAST);
    send_byte(8'hF0, 1'b0, FAST);
    send_byte(8'h74, 1'b0, FAST);
    n_chk++;
    if (right_n !== 1'b1) begin
      n_err++;
      $display("FAIL shared_release: got %b want 1", right_n);
    end
    v0 = n_valid;
    send_byte(8'h29, 1'b0, FAST);
    n_chk++;
    if (n_valid - v0 !== 1 || scan_code !== 8'h29) begin
      n_err++;
      $display("FAIL unmapped_valid: got %0d pulses code %h want 1 29",
               n_valid - v0, scan_code);
    end
    n_chk++;
    if ({right_n, left_n, rotate_n, speed_n} !== 4'b1100) begin
      n_err++;
      $display("FAIL unmapped_held: got %b want 1100",
               {right_n, left_n, rotate_n, speed_n});
    end
    n_chk++;
    if ({scan_ext, scan_brk} !== 2'b00) begin
      n_err++;
      $display("FAIL unmapped_flags: got e%b b%b want 0 0",
               scan_ext, scan_brk);
    end
  endtask

  task automatic test_mid_reset();
    int v0, e0;
    logic [7:0] b;
    b = 8'h23;
    ps2_bit(1'b0, FAST);
    for (int i = 0; i < 4; i++) ps2_bit(b[i], FAST);
    key_data = b[4];
    wait_cyc(FAST);
    key_clk = 1'b0;
    wait_cyc(3);
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({right_n, left_n, rotate_n, speed_n} !== 4'b1111) begin
      n_err++;
      $display("FAIL midrst_held: got %b want 1111",
               {right_n, left_n, rotate_n, speed_n});
    end
    n_chk++;
    if ({scan_code, scan_ext, scan_brk, scan_valid, frame_err} !==
        {8'h00, 4'b0000}) begin
      n_err++;
      $display("FAIL midrst_scan: got %h %b want 00 0000", scan_code,
               {scan_ext, scan_brk, scan_valid, frame_err});
    end
    key_clk = 1'b1;
    key_data = 1'b1;
    wait_cyc(10);
    rst_n = 1'b1;
    wait_cyc(10);
    v0 = n_valid;
    e0 = n_ferr;
    send_byte(8'h23, 1'b0, FAST);
    n_chk++;
    if ({right_n, left_n, rotate_n, speed_n} !== 4'b0111) begin
      n_err++;
      $display("FAIL midrst_recover: got %b want 0111",
               {right_n, left_n, rotate_n, speed_n});
    end
    n_chk++;
    if (n_valid - v0 !== 1 || n_ferr !== e0 || scan_code !== 8'h23) begin
      n_err++;
      $display("FAIL midrst_counts: got valid %0d err %0d code %h want 1 0 23",
               n_valid - v0, n_ferr - e0, scan_code);
    end
  endtask

`ifdef PS2_GLITCH_FILTER_EN
  task automatic test_glitch();
    int e0;
    e0 = n_ferr;
    key_data = 1'b0;
    wait_cyc(5);
    key_clk = 1'b0;
    wait_cyc(3);
    key_clk = 1'b1;
    wait_cyc(FAST);
    key_data = 1'b1;
    wait_cyc(FAST);
    send_byte(8'h1C, 1'b0, FAST);
    n_chk++;
    if (scan_code !== 8'h1C || left_n !== 1'b0 || n_ferr !== e0) begin
      n_err++;
      $display("FAIL glitch: got %h left_n%b err %0d want 1C 0 0",
               scan_code, left_n, n_ferr - e0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_left();
    test_arrow_right();
    test_parity_err();
    test_timeout();
    test_shared();
    test_mid_reset();
`ifdef PS2_GLITCH_FILTER_EN
    test_glitch();
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
